// File: rtl/crypto_ctrl_pkg.sv
// Package: crypto_ctrl_pkg
// Shared definitions for the crypto job arbiter:
//   - op encodings carried on req_op
//   - arbiter FSM state enum
//   - beat-count helpers used to size READ/WRITE/KEYEXP transfers
package crypto_ctrl_pkg;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_KEYEXP = 2'b10;

  localparam int BEAT_W = 32;   // width of one streamed beat
  localparam int BUS_W  = 448;  // register slot width (14 beats)
  localparam int CNT_W  = 6;    // holds beat counts up to 32

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_COMMIT,
    S_KEY,
    S_DONE
  } state_t;

  // Beats per register-file slot, shared by READ and WRITE.
  function automatic logic [CNT_W-1:0] rw_beats(input logic [3:0] sel);
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd8, 4'd9: return 6'd4;
      4'd5, 4'd6:                   return 6'd8;
      4'd12, 4'd13, 4'd14:          return 6'd5;
      4'd4:                         return 6'd14;
      4'd7:                         return 6'd3;
      default:                      return 6'd1;
    endcase
  endfunction

  // Slices loaded per key slot; 0 for slots that do not exist.
  function automatic logic [CNT_W-1:0] key_beats(input logic [3:0] sel);
    case (sel)
      4'd0, 4'd1:       return 6'd4;
      4'd2:             return 6'd5;
      4'd3, 4'd4, 4'd5: return 6'd32;
      default:          return 6'd0;
    endcase
  endfunction

  // Only six key slots exist (writeEnableKey is 6 bits wide).
  function automatic logic key_sel_ok(input logic [3:0] sel);
    return (sel < 4'd6);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Module: rr_pick
// Combinational round-robin picker. Scans req starting at ptr and wrapping
// modulo N_REQ; the first asserted request wins.
// Ports:
//   req     in  N_REQ  request vector
//   ptr     in  PTR_W  highest-priority index for this pick
//   onehot  out N_REQ  one-hot winner (all zero when nothing requests)
//   idx     out PTR_W  binary winner index
//   any     out 1      at least one request present
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = PTR_W'((int'(ptr) + o) % N_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/crypto_job_arbiter.sv
// Module: crypto_job_arbiter
// Shares the coprocessor register file (16 x 448-bit slots) and the key-slice
// loader between N_REQ requesters. One job at a time is chosen round-robin and
// streamed as 32-bit beats:
//   READ   register slot -> requester (rd_valid/rd_data)
//   WRITE  requester -> writeBus, then a one-cycle writeEnable commit
//   KEYEXP key-slice load sequence on writeEnableKey/sliceSelector
// Illegal ops (11) and KEYEXP to a non-existent key slot complete at once
// with done+err and no datapath activity.
// Ports:
//   clock, reset (async, active-high)
//   req_valid/req_op/req_sel/req_wdata  per-requester job request (packed)
//   grant          one-hot owner of the current job
//   wr_ready       combinational: winner's req_wdata is taken at this edge
//   rd_valid/rd_data  read beat stream
//   done/err       one-cycle completion pulse, err marks a rejected job
//   dataOut/selectRead                   register-file read side
//   writeEnable/writeBus                 register-file write side
//   writeEnableKey/sliceSelector         key-slice loader
// Configuration macro: CJA_PRIO0_EN -- requester 0 wins every arbitration it
// takes part in; the pointer then only advances past non-0 winners.
module crypto_job_arbiter
  import crypto_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [4*N_REQ-1:0]   req_sel,
  input  logic [32*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]     grant,
  output logic                 wr_ready,
  output logic                 rd_valid,
  output logic [BEAT_W-1:0]    rd_data,
  output logic                 done,
  output logic                 err,
  input  logic [BUS_W-1:0]     dataOut,
  output logic [3:0]           selectRead,
  output logic [15:0]          writeEnable,
  output logic [BUS_W-1:0]     writeBus,
  output logic [5:0]           writeEnableKey,
  output logic [4:0]           sliceSelector
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_q;
  logic [3:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ctr_q;
  logic             err_q;

  logic [N_REQ-1:0] rr_onehot;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_any;

  logic [N_REQ-1:0] win_onehot;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;

  logic [1:0]       cur_op;
  logic [3:0]       cur_sel;
  logic [CNT_W-1:0] cur_cnt;
  logic             cur_bad;
  logic             beat_left;
  logic [BEAT_W-1:0] win_wdata;
  logic [PTR_W-1:0] ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

`ifdef CJA_PRIO0_EN
  always_comb begin
    win_onehot = rr_onehot;
    win_idx    = rr_idx;
    win_any    = rr_any;
    if (req_valid[0]) begin
      win_onehot    = '0;
      win_onehot[0] = 1'b1;
      win_idx       = '0;
      win_any       = 1'b1;
    end
  end
`else
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
  assign win_any    = rr_any;
`endif

  // Fields of the requester that would win this IDLE cycle.
  assign cur_op  = req_op[2*win_idx +: 2];
  assign cur_sel = req_sel[4*win_idx +: 4];
  assign cur_cnt = (cur_op == OP_KEYEXP) ? key_beats(cur_sel) : rw_beats(cur_sel);
  assign cur_bad = (cur_op == 2'b11) || ((cur_op == OP_KEYEXP) && !key_sel_ok(cur_sel));

  assign beat_left = (ctr_q < cnt_q);
  assign win_wdata = req_wdata[32*win_q +: 32];
  assign ptr_next  = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_any) begin
          if (cur_bad) state_d = S_DONE;
          else begin
            case (cur_op)
              OP_READ:  state_d = S_READ;
              OP_WRITE: state_d = S_WRITE;
              default:  state_d = S_KEY;
            endcase
          end
        end
      end
      S_READ:   if (!beat_left) state_d = S_DONE;
      S_WRITE: begin
        wr_ready = beat_left;
        if (!beat_left) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_DONE;
      S_KEY:    if (!beat_left) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q          <= '0;
      win_q          <= '0;
      sel_q          <= '0;
      cnt_q          <= '0;
      ctr_q          <= '0;
      err_q          <= 1'b0;
      grant          <= '0;
      selectRead     <= '0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      writeEnable    <= '0;
      writeBus       <= '0;
      writeEnableKey <= '0;
      sliceSelector  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_any) begin
            win_q      <= win_idx;
            sel_q      <= cur_sel;
            cnt_q      <= cur_cnt;
            ctr_q      <= '0;
            err_q      <= cur_bad;
            grant      <= win_onehot;
            selectRead <= cur_sel;
          end
        end
        S_READ: begin
          if (beat_left) begin
            rd_data  <= dataOut[32*ctr_q[3:0] +: 32];
            rd_valid <= 1'b1;
            ctr_q    <= ctr_q + 1'b1;
          end else begin
            rd_valid <= 1'b0;
          end
        end
        S_WRITE: begin
          if (beat_left) begin
            writeBus[32*ctr_q[3:0] +: 32] <= win_wdata;
            ctr_q <= ctr_q + 1'b1;
          end else begin
            // Strobe is raised on entry to COMMIT so it lasts exactly that cycle.
            writeEnable <= 16'd1 << sel_q;
          end
        end
        S_COMMIT: begin
          writeEnable <= '0;
          writeBus    <= '0;
        end
        S_KEY: begin
          if (beat_left) begin
            writeEnableKey <= 6'd1 << sel_q;
            sliceSelector  <= ctr_q[4:0];
            ctr_q          <= ctr_q + 1'b1;
          end else begin
            writeEnableKey <= '0;
            sliceSelector  <= '0;
          end
        end
        S_DONE: begin
          grant <= '0;
          err_q <= 1'b0;
`ifdef CJA_PRIO0_EN
          // Requester 0 never consumes a round-robin turn.
          if (win_q != '0) ptr_q <= ptr_next;
`else
          ptr_q <= ptr_next;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_job_arbiter.sv
// Testbench: tb_crypto_job_arbiter
// Directed, self-checking bench for crypto_job_arbiter with N_REQ = 2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived from the beat tables and cycle timing.
module tb_crypto_job_arbiter;

  logic         clock;
  logic         reset;
  logic [1:0]   req_valid;
  logic [3:0]   req_op;
  logic [7:0]   req_sel;
  logic [63:0]  req_wdata;
  logic [1:0]   grant;
  logic         wr_ready;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         done;
  logic         err;
  logic [447:0] dataOut;
  logic [3:0]   selectRead;
  logic [15:0]  writeEnable;
  logic [447:0] writeBus;
  logic [5:0]   writeEnableKey;
  logic [4:0]   sliceSelector;

  int errors = 0;
  int checks = 0;

  crypto_job_arbiter #(.N_REQ(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_sel        (req_sel),
    .req_wdata      (req_wdata),
    .grant          (grant),
    .wr_ready       (wr_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .done           (done),
    .err            (err),
    .dataOut        (dataOut),
    .selectRead     (selectRead),
    .writeEnable    (writeEnable),
    .writeBus       (writeBus),
    .writeEnableKey (writeEnableKey),
    .sliceSelector  (sliceSelector)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{grant, wr_ready, rd_valid, rd_data, done, err, selectRead,
             writeEnable, writeBus, writeEnableKey, sliceSelector};
  endfunction

  initial begin
    int nrd, first_rd, done_cyc, ndone, nw, nwe, nk, ngr, strobes;
    logic [1:0] prev_grant, exp_grant;

    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_sel   = '0;
    req_wdata = '0;
    for (int k = 0; k < 14; k++) dataOut[32*k +: 32] = 32'hA000_0000 + k;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_outputs_held", {63'b0, any_out()}, 64'd0);
    reset = 1'b0;
    tick();
    check("rst_outputs_after", {63'b0, any_out()}, 64'd0);

    // ---------------- 1: req0 READ sel=7 (3 beats) ----------------
    req_valid = 2'b01; req_op[1:0] = 2'b00; req_sel[3:0] = 4'd7;
    nrd = 0; first_rd = -1; done_cyc = -1; ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) check("t1_grant", {62'b0, grant}, 64'd1);
      if (rd_valid) begin
        if (first_rd < 0) first_rd = c;
        check("t1_rd_data", {32'b0, rd_data}, 64'hA000_0000 + 64'(nrd));
        nrd++;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
        check("t1_err", {63'b0, err}, 64'd0);
        req_valid[0] = 1'b0;
      end
      if (done_cyc > 0 && c > done_cyc) break;
    end
    check("t1_first_rd_cycle", 64'(first_rd), 64'd2);
    check("t1_rd_beats", 64'(nrd), 64'd3);
    check("t1_done_cycle", 64'(done_cyc), 64'd5);
    check("t1_done_count", 64'(ndone), 64'd1);
    check("t1_grant_released", {62'b0, grant}, 64'd0);

    // ---------------- 2: req1 WRITE sel=5 (8 beats) ----------------
    req_valid = 2'b10; req_op[3:2] = 2'b01; req_sel[7:4] = 4'd5;
    nw = 0; nwe = 0; done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) check("t2_grant", {62'b0, grant}, 64'd2);
      if (writeEnable != 16'h0) begin
        nwe++;
        check("t2_write_enable", {48'b0, writeEnable}, 64'h0020);
        for (int k = 0; k < 8; k++)
          check("t2_write_bus", {32'b0, writeBus[32*k +: 32]}, 64'(k + 1));
      end
      if (done) begin
        done_cyc = c;
        check("t2_err", {63'b0, err}, 64'd0);
        check("t2_bus_cleared", writeBus[63:0], 64'd0);
        req_valid[1] = 1'b0;
      end
      if (done_cyc > 0 && c > done_cyc) break;
      if (wr_ready) begin
        nw++;
        req_wdata[63:32] = 32'(nw);
      end
    end
    check("t2_beats_taken", 64'(nw), 64'd8);
    check("t2_commit_cycles", 64'(nwe), 64'd1);
    check("t2_done_cycle", 64'(done_cyc), 64'd11);

    // ---------------- 4: both valid, READ sel=3 ----------------
    req_op = 4'b0000; req_sel = {4'd3, 4'd3}; req_valid = 2'b11;
    ngr = 0; prev_grant = 2'b00;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (grant != 2'b00 && prev_grant == 2'b00) begin
`ifdef CJA_PRIO0_EN
        exp_grant = 2'b01;
`else
        exp_grant = (ngr % 2 == 0) ? 2'b01 : 2'b10;
`endif
        check("t4_grant_order", {62'b0, grant}, {62'b0, exp_grant});
        ngr++;
        if (ngr == 4) req_valid = 2'b00;
      end
      prev_grant = grant;
      if (ngr == 4 && grant == 2'b00) break;
    end
    check("t4_grant_count", 64'(ngr), 64'd4);

    // ---------------- 3: req0 KEYEXP sel=3 (32 slices) ----------------
    req_valid = 2'b01; req_op[1:0] = 2'b10; req_sel[3:0] = 4'd3;
    nk = 0; done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (writeEnableKey != 6'b0) begin
        check("t3_key_enable", {58'b0, writeEnableKey}, 64'b001000);
        check("t3_slice", {59'b0, sliceSelector}, 64'(nk));
        nk++;
      end
      if (done) begin
        done_cyc = c;
        check("t3_key_cleared", {53'b0, writeEnableKey, sliceSelector}, 64'd0);
        check("t3_err", {63'b0, err}, 64'd0);
        req_valid[0] = 1'b0;
      end
      if (done_cyc > 0 && c > done_cyc) break;
    end
    check("t3_slice_count", 64'(nk), 64'd32);

    // ---------------- 5: illegal op (req1) and illegal key slot (req0) ----------------
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        req_valid = 2'b10; req_op[3:2] = 2'b11; req_sel[7:4] = 4'd0;
      end else begin
        req_valid = 2'b01; req_op[1:0] = 2'b10; req_sel[3:0] = 4'd9;
      end
      strobes = 0; done_cyc = -1;
      for (int c = 1; c <= 10; c++) begin
        tick();
        if (writeEnable != 16'h0 || writeEnableKey != 6'h0 || rd_valid || wr_ready) strobes++;
        if (done) begin
          done_cyc = c;
          check("t5_err", {63'b0, err}, 64'd1);
          req_valid = 2'b00;
        end
        if (done_cyc > 0 && c > done_cyc) break;
      end
      check("t5_no_strobes", 64'(strobes), 64'd0);
      check("t5_done_latency", {63'b0, (done_cyc >= 1 && done_cyc <= 2)}, 64'd1);
    end

    // ---------------- 6: reset during WRITE beat 2 of sel=4 ----------------
    req_valid = 2'b10; req_op[3:2] = 2'b01; req_sel[7:4] = 4'd4;
    nw = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (wr_ready) begin
        nw++;
        req_wdata[63:32] = 32'h5000_0000 + 32'(nw);
      end
      if (nw == 3) break;
    end
    check("t6_reached_beat2", 64'(nw), 64'd3);
    check("t6_grant_before", {62'b0, grant}, 64'd2);
    req_valid[0] = 1'b1; req_op[1:0] = 2'b00; req_sel[3:0] = 4'd7;
    reset = 1'b1;
    #1;
    check("t6_outputs_cleared", {63'b0, any_out()}, 64'd0);
    nwe = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (writeEnable != 16'h0 || done) nwe++;
    end
    check("t6_no_commit_or_done", 64'(nwe), 64'd0);
    reset = 1'b0;
    tick();
    check("t6_next_grant", {62'b0, grant}, 64'd1);
    req_valid[1] = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        done_cyc = c;
        req_valid = 2'b00;
      end
      if (done_cyc > 0 && c > done_cyc) break;
    end
    check("t6_post_reset_done", {63'b0, (done_cyc > 0)}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
